id_ex_pipe_reg: RTL and testbench
=================================

# id_ex_pipe_reg

Parametrised ID/EX pipeline register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush, and registered opcode decode. It sits between the register-file/sign-extend stage and the ALU stage, replacing the fixed-width always-enabled ID/EX latch. Upstream stalls from EX back-pressure no longer lose instructions. Decoded control bits travel with their payload through both buffer entries. A saturating stall counter supports performance debug.

## Interface
- DATA_WIDTH, 32, width of PC+4, read data and sign-extended immediate
- REG_ADDR_WIDTH, 5, width of register specifier fields
- OPCODE_WIDTH, 6, width of opcode field
- STALL_CNT_WIDTH, 16, width of saturating stall counter

Ports:
- Clk  in  1  single clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; highest priority
- FlushRegisters  in  1  synchronous bubble insert; priority below Reset
- InValid  in  1  ID stage offers a beat
- InReady  out  1  register can accept a beat (registered)
- PC_Plus_4_in, ReadData1_in, ReadData2_in, SignExtend_in  in  DATA_WIDTH each  ID payload
- Rs_in, Rt_in, Rd_in  in  REG_ADDR_WIDTH each  instruction [25:21], [20:16], [15:11]
- OpCode_in  in  OPCODE_WIDTH  instruction [31:26]
- OutValid  out  1  EX-side beat present
- OutReady  in  1  EX stage consumes beat
- PC_Plus_4_out, ReadData1_out, ReadData2_out, SignExtend_out, Rs_out, Rt_out, Rd_out, OpCode_out  out  matching widths  registered payload
- RegDst, ALUSrc, RegWrite, MemRead, MemWrite, MemToReg, Branch, BranchNe, IllegalOp  out  1 each  decoded controls
- ALUOp  out  2  ALU operation class
- StallCount  out  STALL_CNT_WIDTH  cycles with OutValid=1 and OutReady=0

## Operation
- Accept = InValid & InReady.
- Fire = OutValid & OutReady.
- Storage: main entry drives outputs; skid entry holds one overflow beat. Each entry stores payload plus decoded controls.
- Decode is done on the input side. ALUOp/RegDst/ALUSrc/RegWrite/MemRead/MemWrite/MemToReg/Branch/BranchNe per opcode:
  - 000000 R-type: 10/1/0/1/0/0/0/0/0
  - 001000 addi: 01/0/1/1/0/0/0/0/0
  - 100011 lw: 00/0/1/1/1/0/1/0/0
  - 101011 sw: 00/0/1/0/0/1/0/0/0
  - 000100 beq: 11/0/0/0/0/0/0/1/0
  - 000101 bne: 11/0/0/0/0/0/0/1/1
  - any other opcode: all controls 0, IllegalOp=1, payload still passed through.
- States:
  - EMPTY: main invalid.
  - ONE: main valid, skid empty.
  - FULL: both valid.
- Transitions:
  - EMPTY: Accept -> ONE (main<=in).
  - ONE: Fire&Accept -> ONE (main<=in). Fire only -> EMPTY. Accept only -> FULL (skid<=in). Neither -> hold.
  - FULL: Fire -> ONE (main<=skid). Otherwise hold. No Accept is possible because InReady=0.
- OutValid=1 in ONE and FULL. InReady=1 in EMPTY and ONE.
- FlushRegisters=1:
  - Next state is EMPTY.
  - All payload and control outputs are zeroed.
  - A beat accepted in the same cycle is discarded.
  - StallCount is unaffected.
- Reset=1:
  - Next state is EMPTY.
  - All outputs 0, except InReady=1.
  - StallCount=0.
- StallCount increments every cycle with OutValid & ~OutReady. It saturates at all-ones and is not cleared by flush.

## Timing
- Latency: a beat accepted at edge N appears on outputs with OutValid=1 after edge N.
- Throughput: one beat per cycle while OutReady=1.
- InReady falls the cycle after the skid fills. It rises the cycle after FULL->ONE.
- Data ordering is strictly FIFO. No beat is duplicated or dropped except by Flush or Reset.
- Outputs hold stable while OutValid=1 & OutReady=0.
- Reset and Flush asserted together: Reset wins, and StallCount clears.
- Payload outputs are zero whenever state is EMPTY after reset or flush. After a normal drain, outputs retain the last beat.

## Test plan
- Reset, then 4 back-to-back addi beats (PC+4 = 0x4, 0x8, 0xC, 0x10) with OutReady=1 -> each appears one cycle after accept, ALUOp=01, ALUSrc=1, RegWrite=1, InReady stays 1.
- Hold OutReady=0, offer beats A(PC+4=0x20) and B(0x24) -> A on outputs, B in skid, InReady=0 next cycle. Release OutReady -> A then B emitted in order, InReady returns to 1.
- Hold OutReady=0 for 70000 cycles with STALL_CNT_WIDTH=16 -> StallCount saturates at 0xFFFF.
- Assert FlushRegisters in FULL state with InValid=1 (lw beat) -> next cycle OutValid=0, all outputs 0, InReady=1, lw beat lost, StallCount unchanged.
- Opcode sweep: R-type, addi, lw, sw, beq, bne, 0x3F -> controls match the decode list. For 0x3F: IllegalOp=1, controls 0, OpCode_out=0x3F.
- Reset asserted in FULL state together with FlushRegisters -> EMPTY, StallCount=0, then a normal beat passes with 1-cycle latency.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with 2-entry skid buffer, flush and registered decode
module id_ex_pipe_reg #(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int OPCODE_WIDTH    = 6,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       FlushRegisters,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [DATA_WIDTH-1:0]      PC_Plus_4_in,
  input  logic [DATA_WIDTH-1:0]      ReadData1_in,
  input  logic [DATA_WIDTH-1:0]      ReadData2_in,
  input  logic [DATA_WIDTH-1:0]      SignExtend_in,
  input  logic [REG_ADDR_WIDTH-1:0]  Rs_in,
  input  logic [REG_ADDR_WIDTH-1:0]  Rt_in,
  input  logic [REG_ADDR_WIDTH-1:0]  Rd_in,
  input  logic [OPCODE_WIDTH-1:0]    OpCode_in,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [DATA_WIDTH-1:0]      PC_Plus_4_out,
  output logic [DATA_WIDTH-1:0]      ReadData1_out,
  output logic [DATA_WIDTH-1:0]      ReadData2_out,
  output logic [DATA_WIDTH-1:0]      SignExtend_out,
  output logic [REG_ADDR_WIDTH-1:0]  Rs_out,
  output logic [REG_ADDR_WIDTH-1:0]  Rt_out,
  output logic [REG_ADDR_WIDTH-1:0]  Rd_out,
  output logic [OPCODE_WIDTH-1:0]    OpCode_out,
  output logic                       RegDst,
  output logic                       ALUSrc,
  output logic                       RegWrite,
  output logic                       MemRead,
  output logic                       MemWrite,
  output logic                       MemToReg,
  output logic                       Branch,
  output logic                       BranchNe,
  output logic                       IllegalOp,
  output logic [1:0]                 ALUOp,
  output logic [STALL_CNT_WIDTH-1:0] StallCount
);

  localparam int PAY_W = 4*DATA_WIDTH + 3*REG_ADDR_WIDTH + OPCODE_WIDTH;
  // {ALUOp[1:0], RegDst, ALUSrc, RegWrite, MemRead, MemWrite, MemToReg, Branch, BranchNe, IllegalOp}
  localparam int CTL_W = 11;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                     state;
  logic [PAY_W-1:0]           in_pay, main_pay, skid_pay;
  logic [CTL_W-1:0]           in_ctl, main_ctl, skid_ctl;
  logic                       out_valid_q, in_ready_q;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt;
  logic                       accept, fire;

  assign in_pay = {PC_Plus_4_in, ReadData1_in, ReadData2_in, SignExtend_in,
                   Rs_in, Rt_in, Rd_in, OpCode_in};

  assign accept = InValid & in_ready_q;
  assign fire   = out_valid_q & OutReady;

  // Decode the incoming opcode so controls are stored alongside their payload
  always_comb begin
    in_ctl = {2'b00, 8'b0000_0000, 1'b1};
    case (OpCode_in)
      OPCODE_WIDTH'(6'b000000): in_ctl = {2'b10, 8'b1_0_1_0_0_0_0_0, 1'b0};
      OPCODE_WIDTH'(6'b001000): in_ctl = {2'b01, 8'b0_1_1_0_0_0_0_0, 1'b0};
      OPCODE_WIDTH'(6'b100011): in_ctl = {2'b00, 8'b0_1_1_1_0_1_0_0, 1'b0};
      OPCODE_WIDTH'(6'b101011): in_ctl = {2'b00, 8'b0_1_0_0_1_0_0_0, 1'b0};
      OPCODE_WIDTH'(6'b000100): in_ctl = {2'b11, 8'b0_0_0_0_0_0_1_0, 1'b0};
      OPCODE_WIDTH'(6'b000101): in_ctl = {2'b11, 8'b0_0_0_0_0_0_1_1, 1'b0};
      default:                  in_ctl = {2'b00, 8'b0000_0000, 1'b1};
    endcase
  end

  // Main/skid storage FSM; reset and flush both drop every held beat and zero the outputs
  always_ff @(posedge Clk) begin
    if (Reset || FlushRegisters) begin
      state       <= EMPTY;
      main_pay    <= '0;
      main_ctl    <= '0;
      skid_pay    <= '0;
      skid_ctl    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_pay    <= in_pay;
            main_ctl    <= in_ctl;
            out_valid_q <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (fire && accept) begin
            main_pay <= in_pay;
            main_ctl <= in_ctl;
          end else if (fire) begin
            out_valid_q <= 1'b0;
            state       <= EMPTY;
          end else if (accept) begin
            skid_pay   <= in_pay;
            skid_ctl   <= in_ctl;
            in_ready_q <= 1'b0;
            state      <= FULL;
          end
        end
        FULL: begin
          if (fire) begin
            main_pay   <= skid_pay;
            main_ctl   <= skid_ctl;
            in_ready_q <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Saturating count of back-pressured cycles; only reset clears it, flush does not
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt <= '0;
    end else if (out_valid_q && !OutReady && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + STALL_CNT_WIDTH'(1);
    end
  end

  assign {PC_Plus_4_out, ReadData1_out, ReadData2_out, SignExtend_out,
          Rs_out, Rt_out, Rd_out, OpCode_out} = main_pay;
  assign {ALUOp, RegDst, ALUSrc, RegWrite, MemRead, MemWrite, MemToReg,
          Branch, BranchNe, IllegalOp} = main_ctl;
  assign OutValid   = out_valid_q;
  assign InReady    = in_ready_q;
  assign StallCount = stall_cnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - scoreboard bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;

  logic        Clk;
  logic        Reset;
  logic        FlushRegisters;
  logic        InValid;
  logic        InReady;
  logic [31:0] PC_Plus_4_in, ReadData1_in, ReadData2_in, SignExtend_in;
  logic [4:0]  Rs_in, Rt_in, Rd_in;
  logic [5:0]  OpCode_in;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] PC_Plus_4_out, ReadData1_out, ReadData2_out, SignExtend_out;
  logic [4:0]  Rs_out, Rt_out, Rd_out;
  logic [5:0]  OpCode_out;
  logic        RegDst, ALUSrc, RegWrite, MemRead, MemWrite, MemToReg, Branch, BranchNe, IllegalOp;
  logic [1:0]  ALUOp;
  logic [15:0] StallCount;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] se;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  op;
    logic [10:0] ctl;
  } beat_t;

  beat_t       sb[$];
  beat_t       cur;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_stall = 16'd0;

  id_ex_pipe_reg dut (
    .Clk(Clk), .Reset(Reset), .FlushRegisters(FlushRegisters),
    .InValid(InValid), .InReady(InReady),
    .PC_Plus_4_in(PC_Plus_4_in), .ReadData1_in(ReadData1_in),
    .ReadData2_in(ReadData2_in), .SignExtend_in(SignExtend_in),
    .Rs_in(Rs_in), .Rt_in(Rt_in), .Rd_in(Rd_in), .OpCode_in(OpCode_in),
    .OutValid(OutValid), .OutReady(OutReady),
    .PC_Plus_4_out(PC_Plus_4_out), .ReadData1_out(ReadData1_out),
    .ReadData2_out(ReadData2_out), .SignExtend_out(SignExtend_out),
    .Rs_out(Rs_out), .Rt_out(Rt_out), .Rd_out(Rd_out), .OpCode_out(OpCode_out),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .Branch(Branch), .BranchNe(BranchNe),
    .IllegalOp(IllegalOp), .ALUOp(ALUOp), .StallCount(StallCount)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Reference decode: {ALUOp, RegDst, ALUSrc, RegWrite, MemRead, MemWrite, MemToReg, Branch, BranchNe, IllegalOp}
  function automatic logic [10:0] exp_ctl(input logic [5:0] op);
    case (op)
      6'h00:   return 11'b10_1_0_1_0_0_0_0_0_0;
      6'h08:   return 11'b01_0_1_1_0_0_0_0_0_0;
      6'h23:   return 11'b00_0_1_1_1_0_1_0_0_0;
      6'h2B:   return 11'b00_0_1_0_0_1_0_0_0_0;
      6'h04:   return 11'b11_0_0_0_0_0_0_1_0_0;
      6'h05:   return 11'b11_0_0_0_0_0_0_1_1_0;
      default: return 11'b00_0_0_0_0_0_0_0_0_1;
    endcase
  endfunction

  function automatic beat_t obs_beat();
    beat_t b;
    b.pc  = PC_Plus_4_out;
    b.rd1 = ReadData1_out;
    b.rd2 = ReadData2_out;
    b.se  = SignExtend_out;
    b.rs  = Rs_out;
    b.rt  = Rt_out;
    b.rd  = Rd_out;
    b.op  = OpCode_out;
    b.ctl = {ALUOp, RegDst, ALUSrc, RegWrite, MemRead, MemWrite, MemToReg, Branch, BranchNe, IllegalOp};
    return b;
  endfunction

  task automatic chk(input string tag, input logic [159:0] observed, input logic [159:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic offer(input logic [31:0] pc, input logic [5:0] op);
    cur.pc  = pc;
    cur.rd1 = pc ^ 32'hA5A5_5A5A;
    cur.rd2 = ~pc;
    cur.se  = {{16{pc[15]}}, pc[15:0]} ^ 32'h0000_0F0F;
    cur.rs  = pc[6:2];
    cur.rt  = pc[7:3] ^ 5'h1F;
    cur.rd  = pc[8:4];
    cur.op  = op;
    cur.ctl = exp_ctl(op);
    PC_Plus_4_in  = cur.pc;
    ReadData1_in  = cur.rd1;
    ReadData2_in  = cur.rd2;
    SignExtend_in = cur.se;
    Rs_in         = cur.rs;
    Rt_in         = cur.rt;
    Rd_in         = cur.rd;
    OpCode_in     = cur.op;
    InValid       = 1'b1;
  endtask

  // One clock: check handshake/stall against the occupancy model, score fires, enqueue accepts
  task automatic step();
    int    n;
    beat_t b;
    @(negedge Clk);
    n = sb.size();
    chk("out_valid", {159'd0, OutValid}, {159'd0, (n > 0)});
    chk("in_ready", {159'd0, InReady}, {159'd0, (n < 2)});
    chk("stall_count", {144'd0, StallCount}, {144'd0, exp_stall});
    if (n > 0 && OutReady) begin
      b = sb.pop_front();
      chk("fire_beat", obs_beat(), b);
    end
    if (InValid && n < 2 && !Reset && !FlushRegisters) sb.push_back(cur);
    if (n > 0 && !OutReady && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
    if (Reset || FlushRegisters) sb.delete();
    if (Reset) exp_stall = 16'd0;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1; FlushRegisters = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    offer(32'h0, 6'h00);
    InValid = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;

    // Reset state
    chk("reset_out_valid", {159'd0, OutValid}, 160'd0);
    chk("reset_in_ready", {159'd0, InReady}, 160'd1);
    chk("reset_stall", {144'd0, StallCount}, 160'd0);
    chk("reset_outputs", obs_beat(), 160'd0);

    // Back-to-back addi beats with the consumer always ready
    OutReady = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      offer(32'(4 * i), 6'h08);
      step();
      chk("b2b_latency_pc", {128'd0, PC_Plus_4_out}, {128'd0, 32'(4 * i)});
      chk("b2b_ctl", {149'd0, ALUOp, RegDst, ALUSrc, RegWrite, MemRead, MemWrite, MemToReg, Branch, BranchNe, IllegalOp},
          {149'd0, 11'b01_0_1_1_0_0_0_0_0_0});
    end
    InValid = 1'b0;
    step();
    step();
    chk("drain_retain_pc", {128'd0, PC_Plus_4_out}, {128'd0, 32'h10});

    // Back-pressure: A on outputs, B in skid, then release in order
    OutReady = 1'b0;
    offer(32'h20, 6'h08);
    step();
    offer(32'h24, 6'h08);
    step();
    InValid = 1'b0;
    chk("full_in_ready", {159'd0, InReady}, 160'd0);
    repeat (3) step();
    chk("stall_hold_pc", {128'd0, PC_Plus_4_out}, {128'd0, 32'h20});
    OutReady = 1'b1;
    step();
    chk("release_b_pc", {128'd0, PC_Plus_4_out}, {128'd0, 32'h24});
    chk("release_in_ready", {159'd0, InReady}, 160'd1);
    step();
    step();

    // Saturate the stall counter in FULL
    OutReady = 1'b0;
    offer(32'h30, 6'h08);
    step();
    offer(32'h34, 6'h2B);
    step();
    InValid = 1'b0;
    repeat (70000) @(posedge Clk);
    #1;
    exp_stall = 16'hFFFF;
    chk("stall_saturated", {144'd0, StallCount}, {144'd0, 16'hFFFF});

    // Flush in FULL with a lw beat offered: everything dropped, counter kept
    offer(32'h40, 6'h23);
    FlushRegisters = 1'b1;
    step();
    FlushRegisters = 1'b0;
    InValid = 1'b0;
    chk("flush_out_valid", {159'd0, OutValid}, 160'd0);
    chk("flush_in_ready", {159'd0, InReady}, 160'd1);
    chk("flush_outputs", obs_beat(), 160'd0);
    chk("flush_stall", {144'd0, StallCount}, {144'd0, 16'hFFFF});
    OutReady = 1'b1;
    repeat (2) step();

    // Opcode sweep including an illegal opcode
    begin
      logic [5:0] ops [7] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F};
      for (int i = 0; i < 7; i++) begin
        offer(32'h100 + 32'(4 * i), ops[i]);
        step();
      end
    end
    InValid = 1'b0;
    chk("illegal_flag", {159'd0, IllegalOp}, 160'd1);
    chk("illegal_opcode", {154'd0, OpCode_out}, {154'd0, 6'h3F});
    chk("illegal_ctl", {150'd0, ALUOp, RegDst, ALUSrc, RegWrite, MemRead, MemWrite, MemToReg, Branch, BranchNe}, 160'd0);
    repeat (2) step();

    // Reset together with flush while FULL
    OutReady = 1'b0;
    offer(32'h180, 6'h00);
    step();
    offer(32'h184, 6'h05);
    step();
    InValid = 1'b0;
    step();
    Reset = 1'b1;
    FlushRegisters = 1'b1;
    step();
    Reset = 1'b0;
    FlushRegisters = 1'b0;
    chk("rst_flush_stall", {144'd0, StallCount}, 160'd0);
    chk("rst_flush_out_valid", {159'd0, OutValid}, 160'd0);
    chk("rst_flush_outputs", obs_beat(), 160'd0);
    OutReady = 1'b1;
    offer(32'h200, 6'h04);
    step();
    InValid = 1'b0;
    chk("post_reset_pc", {128'd0, PC_Plus_4_out}, {128'd0, 32'h200});
    chk("post_reset_branch", {159'd0, Branch}, 160'd1);
    repeat (2) step();
    chk("scoreboard_empty", 160'(sb.size()), 160'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
